mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-ported unified memory between the multicycle MIPS core (port 0) and a second bus master such as a loader or DMA engine (port 1). It chooses one requester per cycle and steers that requester's address, write data and write enable onto the memory port. It registers read data back to the granted requester, bounds each owner's tenure with a burst limit, and supports a lock for atomic read-modify-write sequences. It sits between the core's `mem_addr`/`mem_wr_data`/`mem_wr_ena`/`mem_rd_data` pins and the memory model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, maximum consecutive grants to one owner while the other port waits (must be ≥1)

- `clk`  in  1  single clock, rising edge
- `rstb`  in  1  reset; asynchronous, active-low
- `m0_req`, `m1_req`  in  1  access request; held with fields stable until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_lock`, `m1_lock`  in  1  keep ownership while asserted (honored only for the current owner)
- `m0_addr`, `m1_addr`  in  ADDR_W  access address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_gnt`, `m1_gnt`  out  1  access performed this cycle (combinational)
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data
- `m0_rvalid`, `m1_rvalid`  out  1  rdata updated at the last edge (one-cycle pulse)
- `mem_addr`  out  ADDR_W  to memory
- `mem_wr_data`  out  DATA_W  to memory
- `mem_wr_ena`  out  1  to memory; write on the rising edge
- `mem_rd_data`  in  DATA_W  combinational read data from memory

## Operation
- State registers:
  - `owner` ∈ {NONE, P0, P1}
  - `cnt`, width clog2(MAX_BURST)+1, saturating at MAX_BURST-1
  - `rr`: the port favored on the next tie from NONE
- Winner computation (combinational, evaluated each cycle, first matching rule applies):
  1. The owner asserts req and lock → winner = owner.
  2. The owner asserts req and the other port does not → winner = owner.
  3. Both ports request, owner ≠ NONE, and cnt < MAX_BURST-1 → winner = owner.
  4. Both ports request and owner ≠ NONE → winner = the non-owner.
  5. Both ports request and owner = NONE → winner = rr.
  6. Exactly one port requests → winner = that port.
  7. Otherwise → winner = NONE.
- Outputs follow the winner:
  - `mi_gnt` = (winner == Pi).
  - Memory pins are muxed from the winner's fields: `mem_wr_ena` = the winner's `we`.
  - When winner = NONE: `mem_addr` = 0, `mem_wr_data` = 0, `mem_wr_ena` = 0.
- Registered update on each rising edge:
  - `owner` ← winner.
  - `cnt` ← (winner == owner && winner ≠ NONE) ? min(cnt+1, MAX_BURST-1) : 0.
  - `rr` ← (winner == P0) ? P1 : (winner == P1) ? P0 : rr.
- Read return:
  - If `mi_gnt` and not `mi_we`: `mi_rdata` ← `mem_rd_data` and `mi_rvalid` ← 1.
  - Otherwise `mi_rvalid` ← 0 and `mi_rdata` holds its value.
- Lock behavior:
  - Lock overrides the burst limit; `cnt` keeps saturating while the lock is held.
  - A lock asserted by the non-owner has no effect until that port wins under the normal rules.
  - When the owner drops req, ownership is released even if lock is still asserted.
- Requester contract:
  - The arbiter does not queue requests.
  - An ungranted requester holds req, we, addr and wdata stable.
  - Dropping req before grant is legal; the request is simply lost.

## Timing
- Reset values: owner = NONE, cnt = 0, rr = P0, `m0_rdata` = `m1_rdata` = 0, `m0_rvalid` = `m1_rvalid` = 0.
- While `rstb` is low, `m0_gnt`, `m1_gnt` and `mem_wr_ena` are forced to 0 regardless of requests, so no write can occur during reset.
- Reset asserted mid-burst or mid-lock clears all state immediately. After release, arbitration restarts from NONE with rr = P0.
- Grant latency is 0 cycles when winner is computed in the same cycle as req; an uncontested request is granted in the cycle it is raised.
- A write commits at the rising edge that ends the grant cycle.
- Read data appears on `mi_rdata` with `mi_rvalid` = 1 one cycle after the grant cycle.
- Fairness: with both ports requesting continuously and no lock, each owner gets exactly MAX_BURST consecutive grants, then ownership alternates. Worst-case wait is MAX_BURST cycles.
- Back-to-back reads by one owner produce consecutive rvalid pulses, one per grant.

## Test plan
- Reset, then m0 reads addr 0x10 holding 0xDEADBEEF alone:
  - `m0_gnt` = 1 in the same cycle and `mem_addr` = 0x10.
  - Next cycle `m0_rdata` = 0xDEADBEEF and `m0_rvalid` = 1 for exactly one cycle.
- Both ports request from NONE right after reset → m0 wins first (rr = P0). If only m1 then requests, m1 is granted in that cycle.
- Both ports request continuously, MAX_BURST = 4 → grant pattern is m0×4, m1×4, m0×4, ... and `cnt` never exceeds 3.
- m1 owns with lock = 1 and req held for 10 cycles while m0 requests → m1 is granted all 10 cycles. m0 is granted in the first cycle after m1 drops req.
- m0 writes 0x1234 to 0x20 while m1 waits:
  - `mem_wr_ena` = 1 only during the m0 grant cycle.
  - A subsequent m1 read of 0x20 returns 0x1234.
  - `mem_wr_ena` = 0 in all cycles with no grant.
- `rstb` is pulsed low asynchronously during an m1 locked burst:
  - Grants and `mem_wr_ena` drop immediately, and both rvalid outputs and both rdata outputs are 0.
  - After release with both ports requesting, m0 is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : two-port arbiter sharing one single-ported memory between the core (port 0) and a second master (port 1).
// Latency : grant is combinational in the request cycle; read data/rvalid are registered, one cycle after the grant.
// Backpress: no queuing; an ungranted requester holds req and fields stable until m*_gnt, burst limit bounds its wait.
//
// Ports:
//   clk, rstb                 clock (rising edge) and asynchronous active-low reset
//   m*_req/we/lock/addr/wdata requester fields for port 0 / port 1
//   m*_gnt                    access performed this cycle (combinational)
//   m*_rdata, m*_rvalid       registered read data and its one-cycle valid pulse
//   mem_addr/wr_data/wr_ena   muxed memory command; mem_rd_data is combinational read data
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_ena,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int              CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d, winner;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;         // 0: port 0 favoured on a tie from NONE
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;

  logic owner_req, owner_lock, other_req, both_req;

  // Winner selection; rules are ordered, the first match applies.
  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    other_req  = 1'b0;
    both_req   = m0_req & m1_req;
    winner     = OWN_NONE;

    case (owner_q)
      OWN_P0: begin
        owner_req  = m0_req;
        owner_lock = m0_lock;
        other_req  = m1_req;
      end
      OWN_P1: begin
        owner_req  = m1_req;
        owner_lock = m1_lock;
        other_req  = m0_req;
      end
      default: ;
    endcase

    if (owner_req && owner_lock) begin
      winner = owner_q;
    end else if (owner_req && !other_req) begin
      winner = owner_q;
    end else if (both_req && owner_q != OWN_NONE && cnt_q < CNT_MAX) begin
      winner = owner_q;
    end else if (both_req && owner_q != OWN_NONE) begin
      winner = (owner_q == OWN_P0) ? OWN_P1 : OWN_P0;
    end else if (both_req) begin
      winner = rr_q ? OWN_P1 : OWN_P0;
    end else if (m0_req) begin
      winner = OWN_P0;
    end else if (m1_req) begin
      winner = OWN_P1;
    end

    // Nothing may reach the memory while reset is held.
    if (!rstb) begin
      winner = OWN_NONE;
    end
  end

  // Memory steering and grants.
  always_comb begin
    m0_gnt      = (winner == OWN_P0);
    m1_gnt      = (winner == OWN_P1);
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    case (winner)
      OWN_P0: begin
        mem_addr    = m0_addr;
        mem_wr_data = m0_wdata;
        mem_wr_ena  = m0_we;
      end
      OWN_P1: begin
        mem_addr    = m1_addr;
        mem_wr_data = m1_wdata;
        mem_wr_ena  = m1_we;
      end
      default: ;
    endcase
  end

  // Ownership, burst counter, tie-break pointer and read return.
  always_comb begin
    owner_d = winner;
    cnt_d   = '0;
    rr_d    = rr_q;

    // cnt saturates rather than wrapping so a long lock cannot alias back below the limit.
    if (winner == owner_q && winner != OWN_NONE) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    if (winner == OWN_P0) begin
      rr_d = 1'b1;
    end else if (winner == OWN_P1) begin
      rr_d = 1'b0;
    end

    m0_rdata_d  = m0_rdata_q;
    m0_rvalid_d = 1'b0;
    m1_rdata_d  = m1_rdata_q;
    m1_rvalid_d = 1'b0;
    if (m0_gnt && !m0_we) begin
      m0_rdata_d  = mem_rd_data;
      m0_rvalid_d = 1'b1;
    end
    if (m1_gnt && !m1_we) begin
      m1_rdata_d  = mem_rd_data;
      m1_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      m0_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rdata_q  <= '0;
      m1_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      m0_rdata_q  <= m0_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_rdata  = m0_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule
